rename_table: RTL and testbench

RENAME_TABLE -- requirements
Module: rename_table

---
 rtl/rename_table_if.sv | 54 +++++
 rtl/rename_table.sv | 82 ++++++++
 tb/tb_rename_table.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rename_table_if.sv
// Rename table bus: rename-side request/response, freelist head, and
// backend (writeback / commit / flush) signals.
//
// Handshake: a rename request is offered with i_valid and its fields
// (i_rd_we, i_rd, i_rs1, i_rs2). It is taken on the clock edge where o_ready=1.
// While o_ready=0 the requester holds every request field stable. o_fl_re
// pops the freelist head, presented on i_fl_prd, on that same edge.
//
// Modports:
//   slave  - the rename table (consumes requests, produces mappings)
//   master - the requester/backend side that drives the requests
interface rename_table_if #(
  parameter int AWIDTH = 5,
  parameter int PWIDTH = 6
);
  // rename side
  logic              i_valid;
  logic              i_rd_we;
  logic [AWIDTH-1:0] i_rd;
  logic [AWIDTH-1:0] i_rs1;
  logic [AWIDTH-1:0] i_rs2;
  logic [PWIDTH-1:0] o_prs1;
  logic [PWIDTH-1:0] o_prs2;
  logic              o_rdy1;
  logic              o_rdy2;
  logic [PWIDTH-1:0] o_prd;
  logic [PWIDTH-1:0] o_old_prd;
  logic              o_ready;
  // freelist side
  logic [PWIDTH-1:0] i_fl_prd;
  logic              i_fl_empty;
  logic              o_fl_re;
  // backend
  logic              i_wb_valid;
  logic [PWIDTH-1:0] i_wb_prd;
  logic              i_cmt_valid;
  logic [AWIDTH-1:0] i_cmt_rd;
  logic [PWIDTH-1:0] i_cmt_prd;
  logic              i_flush;

  modport slave (
    input  i_valid, i_rd_we, i_rd, i_rs1, i_rs2,
    input  i_fl_prd, i_fl_empty,
    input  i_wb_valid, i_wb_prd, i_cmt_valid, i_cmt_rd, i_cmt_prd, i_flush,
    output o_prs1, o_prs2, o_rdy1, o_rdy2, o_prd, o_old_prd, o_ready, o_fl_re
  );

  modport master (
    output i_valid, i_rd_we, i_rd, i_rs1, i_rs2,
    output i_fl_prd, i_fl_empty,
    output i_wb_valid, i_wb_prd, i_cmt_valid, i_cmt_rd, i_cmt_prd, i_flush,
    input  o_prs1, o_prs2, o_rdy1, o_rdy2, o_prd, o_old_prd, o_ready, o_fl_re
  );
endinterface

// File: rtl/rename_table.sv
// Register rename table: speculative map (smap), committed map (cmap) and
// a per-physical-register ready vector (rdy).
//
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset (identity maps, all ready)
//   bus    - rename_table_if.slave: rename request/response, freelist
//            head/pop, writeback, commit and flush
//
// Source lookups are combinational and see the map as it was before this
// cycle's allocation. Physical register 0 is the hardwired zero register:
// arch x0 always reads phys 0, and phys 0 always reads ready.
// The interface instance must use the same AWIDTH/PWIDTH as this module,
// and PWIDTH must be at least AWIDTH.
module rename_table #(
  parameter int AWIDTH = 5,
  parameter int PWIDTH = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rename_table_if.slave  bus
);
  localparam int NREG  = 1 << AWIDTH;
  localparam int NPHYS = 1 << PWIDTH;

  logic [PWIDTH-1:0] smap [NREG];
  logic [PWIDTH-1:0] cmap [NREG];
  logic [NPHYS-1:0]  rdy;

  logic              alloc;
  logic              cmt_we;
  logic [PWIDTH-1:0] prs1;
  logic [PWIDTH-1:0] prs2;

  assign alloc  = bus.i_valid && bus.i_rd_we && (bus.i_rd != '0);
  assign cmt_we = bus.i_cmt_valid && (bus.i_cmt_rd != '0);

  // x0 is forced rather than trusted to the array so it stays 0 regardless
  // of what the stored entry holds.
  assign prs1 = (bus.i_rs1 == '0) ? '0 : smap[bus.i_rs1];
  assign prs2 = (bus.i_rs2 == '0) ? '0 : smap[bus.i_rs2];

  always_comb begin
    bus.o_prs1    = prs1;
    bus.o_prs2    = prs2;
    // Same-cycle writeback bypass so a producer finishing now is seen ready.
    bus.o_rdy1    = (prs1 == '0) || rdy[prs1] || (bus.i_wb_valid && (bus.i_wb_prd == prs1));
    bus.o_rdy2    = (prs2 == '0) || rdy[prs2] || (bus.i_wb_valid && (bus.i_wb_prd == prs2));
    bus.o_prd     = alloc ? bus.i_fl_prd : '0;
    bus.o_old_prd = alloc ? smap[bus.i_rd] : '0;
    bus.o_ready   = bus.i_valid && !bus.i_flush && !i_rst && (!alloc || !bus.i_fl_empty);
    bus.o_fl_re   = bus.o_ready && alloc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        smap[i] <= PWIDTH'(i);
        cmap[i] <= PWIDTH'(i);
      end
      rdy <= '1;
    end else begin
      if (cmt_we) cmap[bus.i_cmt_rd] <= bus.i_cmt_prd;

      if (bus.i_flush) begin
        // Restore from the committed map including this cycle's commit.
        for (int i = 0; i < NREG; i++) begin
          if (cmt_we && (bus.i_cmt_rd == AWIDTH'(i))) smap[i] <= bus.i_cmt_prd;
          else                                        smap[i] <= cmap[i];
        end
        rdy <= '1;
      end else begin
        if (bus.i_wb_valid) rdy[bus.i_wb_prd] <= 1'b1;
        // Placed after the writeback set so the allocation clear wins.
        if (bus.o_fl_re) begin
          smap[bus.i_rd]   <= bus.i_fl_prd;
          rdy[bus.i_fl_prd] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rename_table.sv
module tb_rename_table;
  localparam int AW = 5;
  localparam int PW = 6;
  localparam int W  = 4 * PW + 4;

  // clock/reset
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  rename_table_if #(.AWIDTH(AW), .PWIDTH(PW)) bus ();

  rename_table #(.AWIDTH(AW), .PWIDTH(PW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  // scoreboard
  logic [W-1:0] exp_q [$];
  string        name_q [$];
  int           n_vec = 0;
  int           n_err = 0;

  // driver tasks
  task automatic set_idle();
    i_rst          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_rd_we    = 1'b0;
    bus.i_rd       = '0;
    bus.i_rs1      = '0;
    bus.i_rs2      = '0;
    bus.i_fl_prd   = '0;
    bus.i_fl_empty = 1'b0;
    bus.i_wb_valid = 1'b0;
    bus.i_wb_prd   = '0;
    bus.i_cmt_valid = 1'b0;
    bus.i_cmt_rd   = '0;
    bus.i_cmt_prd  = '0;
    bus.i_flush    = 1'b0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    set_idle();
  endtask

  task automatic req(input logic rd_we, input int rd, input int rs1, input int rs2, input int fl_prd);
    bus.i_valid  = 1'b1;
    bus.i_rd_we  = rd_we;
    bus.i_rd     = AW'(rd);
    bus.i_rs1    = AW'(rs1);
    bus.i_rs2    = AW'(rs2);
    bus.i_fl_prd = PW'(fl_prd);
  endtask

  task automatic look(input int rs1, input int rs2);
    bus.i_rs1 = AW'(rs1);
    bus.i_rs2 = AW'(rs2);
  endtask

  task automatic expect_out(input string name, input int prs1, input int prs2,
                            input logic rdy1, input logic rdy2, input int prd,
                            input int old_prd, input logic ready, input logic fl_re);
    exp_q.push_back({PW'(prs1), PW'(prs2), rdy1, rdy2, PW'(prd), PW'(old_prd), ready, fl_re});
    name_q.push_back(name);
  endtask

  // monitor: every driven vector is sampled mid-cycle and checked
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      string        nm;
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {bus.o_prs1, bus.o_prs2, bus.o_rdy1, bus.o_rdy2,
              bus.o_prd, bus.o_old_prd, bus.o_ready, bus.o_fl_re};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s: got {prs1=%0d prs2=%0d rdy=%b%b prd=%0d old=%0d ready=%b fl_re=%b} want {prs1=%0d prs2=%0d rdy=%b%b prd=%0d old=%0d ready=%b fl_re=%b}",
                 nm, got[W-1 -: PW], got[W-1-PW -: PW], got[2*PW+3], got[2*PW+2],
                 got[2*PW+1 -: PW], got[PW+1 -: PW], got[1], got[0],
                 want[W-1 -: PW], want[W-1-PW -: PW], want[2*PW+3], want[2*PW+2],
                 want[2*PW+1 -: PW], want[PW+1 -: PW], want[1], want[0]);
      end
    end
  end

  initial begin
    set_idle();
    i_rst = 1'b1;
    @(posedge i_clk);  // first reset edge initialises the maps

    // still in reset; an allocating request must not be accepted
    step(); i_rst = 1'b1; req(1'b1, 3, 5, 0, 32);
    expect_out("reset_lookup", 5, 0, 1, 1, 32, 3, 0, 0);

    step(); req(1'b1, 3, 3, 4, 32);
    expect_out("alloc_x3", 3, 4, 1, 1, 32, 3, 1, 1);

    step(); look(3, 5);
    expect_out("x3_now_32_busy", 32, 5, 0, 1, 0, 0, 0, 0);

    step(); look(3, 5); bus.i_wb_valid = 1'b1; bus.i_wb_prd = 6'd32;
    expect_out("wb_bypass", 32, 5, 1, 1, 0, 0, 0, 0);

    step(); look(3, 5);
    expect_out("wb_sticky", 32, 5, 1, 1, 0, 0, 0, 0);

    step(); req(1'b1, 4, 4, 3, 33); bus.i_fl_empty = 1'b1;
    expect_out("empty_stall", 4, 32, 1, 1, 33, 4, 0, 0);

    step(); req(1'b0, 4, 4, 0, 33); bus.i_fl_empty = 1'b1;
    expect_out("empty_nonalloc", 4, 0, 1, 1, 0, 0, 1, 0);

    step(); req(1'b1, 4, 4, 3, 33);
    bus.i_cmt_valid = 1'b1; bus.i_cmt_rd = 5'd3; bus.i_cmt_prd = 6'd32;
    expect_out("alloc_x4_cmt_x3", 4, 32, 1, 1, 33, 4, 1, 1);

    step(); req(1'b1, 5, 4, 3, 34); bus.i_flush = 1'b1;
    bus.i_cmt_valid = 1'b1; bus.i_cmt_rd = 5'd4; bus.i_cmt_prd = 6'd33;
    expect_out("flush_blocks", 33, 32, 0, 1, 34, 5, 0, 0);

    step(); look(3, 4);
    expect_out("after_flush", 32, 33, 1, 1, 0, 0, 0, 0);

    step(); look(5, 0);
    expect_out("flush_no_alloc", 5, 0, 1, 1, 0, 0, 0, 0);

    step(); req(1'b1, 0, 0, 6, 40);
    expect_out("rd0_no_alloc", 0, 6, 1, 1, 0, 0, 1, 0);

    step(); look(0, 6);
    expect_out("x0_still_0", 0, 6, 1, 1, 0, 0, 0, 0);

    step(); req(1'b1, 6, 6, 7, 40); bus.i_wb_valid = 1'b1; bus.i_wb_prd = 6'd40;
    expect_out("alloc_with_wb", 6, 7, 1, 1, 40, 6, 1, 1);

    step(); look(6, 7);
    expect_out("clear_wins", 40, 7, 0, 1, 0, 0, 0, 0);

    step(); i_rst = 1'b1; req(1'b1, 7, 6, 7, 41); bus.i_fl_empty = 1'b1;
    bus.i_flush = 1'b1; bus.i_wb_valid = 1'b1; bus.i_wb_prd = 6'd41;
    expect_out("reset_mid_stall", 40, 7, 0, 1, 41, 7, 0, 0);

    step(); look(6, 3);
    expect_out("after_reset", 6, 3, 1, 1, 0, 0, 0, 0);

    step(); bus.i_cmt_valid = 1'b1; bus.i_cmt_rd = 5'd0; bus.i_cmt_prd = 6'd50;
    look(0, 3);
    expect_out("cmt_x0", 0, 3, 1, 1, 0, 0, 0, 0);

    step(); bus.i_flush = 1'b1; req(1'b0, 0, 0, 3, 0);
    expect_out("flush_ready0", 0, 3, 1, 1, 0, 0, 0, 0);

    step(); look(0, 3);
    expect_out("x0_after_flush", 0, 3, 1, 1, 0, 0, 0, 0);

    step();
    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge i_clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
